logic_cluster: RTL and testbench
================================

// Module: logic_cluster
// PURPOSE
//  N-element configurable logic cluster; each element is a K-input LUT plus optional register.
//  Configuration arrives over a daisy-chained serial shift path clocked by the fabric clock.
//  A shadow/active register pair plus a small load FSM make commits atomic and length-checked.
//  Sits between routing and the next cluster in the config chain; prog_out feeds the next prog_in.
// PARAMETERS
//  K      4   LUT inputs per element (2..6)
//  N      4   elements per cluster (1..16)
//  LE_W   derived, 2**K+4: config bits per element
//  CFG_W  derived, N*LE_W: cluster frame bits, 80 at defaults
// PORTS
//  clk        in   1      fabric clock; everything samples on posedge
//  rst_n      in   1      asynchronous, active-low reset
//  prog_en    in   1      high = shifting frame; falling edge requests commit
//  prog_in    in   1      serial config bit, sampled when prog_en=1
//  prog_out   out  1      MSB of shadow register, feeds next cluster's prog_in
//  in         in   N*K    element inputs; element j uses in[j*K +: K]
//  out        out  N      element outputs
//  cfg_busy   out  1      FSM in SHIFT
//  cfg_done   out  1      one-cycle pulse, commit accepted
//  cfg_err    out  1      sticky, frame rejected; cleared by next accepted commit or reset
// BEHAVIOUR
//  Reset (async assert, sync release): shadow, active config, element FFs, counter = 0; FSM=IDLE;
//   out=0 (all-zero LUT), prog_out=0, cfg_busy=0, cfg_done=0, cfg_err=0.
//  Shift: each clk with prog_en=1, shadow <= {shadow[CFG_W-2:0], prog_in}; first bit ends at MSB.
//  Bit counter counts shifted bits, saturates at CFG_W+1; longer frames pass downstream via prog_out.
//  FSM: IDLE -prog_en=1-> SHIFT (that cycle's bit is counted);
//   SHIFT -prog_en=0-> COMMIT; COMMIT -> IDLE unconditionally, one cycle.
//  COMMIT with count>=CFG_W: active<=shadow, each FF<=ff_init, cfg_done=1 next cycle, cfg_err<=0.
//  COMMIT with count<CFG_W: active unchanged, FFs unchanged, cfg_err<=1, no cfg_done.
//  prog_en re-asserted in the COMMIT cycle: the commit completes; FSM then goes IDLE->SHIFT next cycle.
//  Counter clears on IDLE->SHIFT.
//  Element j field, bits [j*LE_W +: LE_W]: [2**K-1:0] LUT truth table; +0 ff_en_sel; +1 fb_sel;
//   +2 out_sel; +3 ff_init (offsets from bit 2**K).
//  LUT index = element inputs with bit 0 replaced by the element FF when fb_sel=1.
//  lut_out = table[index], combinational.
//  FF enable = 1 if ff_en_sel=0, else input bit K-1. FF <= lut_out on enabled posedge clk.
//   A COMMIT cycle overrides the enable.
//  out[j] = out_sel ? FF : lut_out.
//  Elements keep running on the old active config throughout SHIFT; no glitch before commit.
// CONFIGURATION
//  CFG_PARITY_EN defined: frame is CFG_W+1 bits; extra parity bit shifts in last, at shadow[0].
//   Shadow is CFG_W+1 wide; prog_out is shadow[CFG_W]; counter saturates at CFG_W+2.
//   Commit additionally requires even parity over all CFG_W+1 bits; mismatch -> cfg_err=1, no commit.
//   Config bits are shadow[CFG_W:1].
//  CFG_PARITY_EN undefined: CFG_W-bit frame, length check only.
// STRUCTURE
//  Package fpga_cfg_pkg holds: LE_W/CFG_W calculation functions; field offsets FLD_FF_EN_SEL,
//   FLD_FB_SEL, FLD_OUT_SEL, FLD_FF_INIT; FSM state encoding (IDLE/SHIFT/COMMIT) shared with other tiles.
//  Sub-module logic_element_k (param K): LUT mux, feedback/enable/output muxes, FF with commit-load.
//   Instantiated N times via generate.
//  Cluster top owns the shadow/active registers, counter and FSM.
// TESTING
//  Defaults K=4, N=4, CFG_W=80.
//  1 Reset mid-shift after 40 bits -> shadow/active cleared, out=0, FSM IDLE, no cfg_done.
//  2 80-bit frame: all elements AND4 (0x8000), out_sel=0; in=16'hFFFF -> out=4'hF;
//    in[3:0]=4'hE -> out[0]=0; cfg_done pulses once.
//  3 79-bit frame -> cfg_err=1, out unchanged from previous config; valid 80-bit frame -> cfg_err=0.
//  4 Element 0 toggle: table 0x5555, fb_sel=1, out_sel=1, ff_init=0, ff_en_sel=0
//    -> out[0] alternates 1,0,1 each clk after commit.
//  5 Element 1 ff_en_sel=1 with in[7]=0 -> FF holds; in[7]=1 -> FF captures lut_out next edge.
//  6 Two clusters chained, 160-bit frame -> each gets its 80-bit field, both cfg_done.
//    With CFG_PARITY_EN, one flipped bit -> both cfg_err=1.

Source files
------------

// File: rtl/logic_cluster_pkg.sv
// Shared FPGA configuration package.
//   Provides the per-element and per-cluster configuration width
//   calculations, the control-field offsets inside an element field
//   (relative to the end of the LUT truth table), and the configuration
//   load FSM state encoding used by every tile on the config chain.
package fpga_cfg_pkg;

    // Config bits per logic element: 2**k truth-table bits + 4 control bits
    function automatic int calc_le_w(input int k);
        return (2 ** k) + 4;
    endfunction

    // Cluster frame bits: n elements of calc_le_w(k) bits each
    function automatic int calc_cfg_w(input int k, input int n);
        return n * calc_le_w(k);
    endfunction

    // Control-field offsets, counted from bit 2**K of an element field
    localparam int FLD_FF_EN_SEL = 0;
    localparam int FLD_FB_SEL    = 1;
    localparam int FLD_OUT_SEL   = 2;
    localparam int FLD_FF_INIT   = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/logic_cluster_if.sv
// Logic cluster bus interface.
//   Groups the serial configuration handshake and the element data bus.
//   master: the driver side (routing / upstream config source)
//   slave : the cluster side
//   prog_en, prog_in : serial config shift enable and data
//   prog_out         : shadow MSB, drives the next cluster's prog_in
//   in  [N*K]        : element inputs, element j uses in[j*K +: K]
//   out [N]          : element outputs
//   cfg_busy, cfg_done, cfg_err : load FSM status
interface logic_cluster_if #(
    parameter int K = 4,
    parameter int N = 4
) ();
    logic           prog_en;
    logic           prog_in;
    logic           prog_out;
    logic [N*K-1:0] in;
    logic [N-1:0]   out;
    logic           cfg_busy;
    logic           cfg_done;
    logic           cfg_err;

    modport master (
        output prog_en, prog_in, in,
        input  prog_out, out, cfg_busy, cfg_done, cfg_err
    );

    modport slave (
        input  prog_en, prog_in, in,
        output prog_out, out, cfg_busy, cfg_done, cfg_err
    );
endinterface

// File: rtl/logic_cluster_le.sv
// logic_element_k: one K-input LUT with an optional output register.
//   clk, rst_n : fabric clock, asynchronous active-low reset
//   cfg_i      : active element field {ff_init, out_sel, fb_sel, ff_en_sel, table}
//   commit_i   : accepted commit this cycle; loads the FF with init_i
//   init_i     : ff_init bit of the configuration being committed
//   in_i       : element inputs
//   out_o      : element output (LUT or FF, selected by out_sel)
module logic_element_k
    import fpga_cfg_pkg::*;
#(
    parameter int K = 4,
    localparam int LE_W = calc_le_w(K)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [LE_W-1:0] cfg_i,
    input  logic            commit_i,
    input  logic            init_i,
    input  logic [K-1:0]    in_i,
    output logic            out_o
);
    localparam int TBL_W = 2 ** K;

    logic [TBL_W-1:0] tbl;
    logic             ff_en_sel, fb_sel, out_sel;
    logic [K-1:0]     idx;
    logic             lut_out, ff_en;
    logic             ff_q, ff_d;
    // The stored ff_init only matters at commit time, where the incoming
    // frame's copy is used instead (init_i).
    logic             unused_init;

    assign tbl         = cfg_i[TBL_W-1:0];
    assign ff_en_sel   = cfg_i[TBL_W + FLD_FF_EN_SEL];
    assign fb_sel      = cfg_i[TBL_W + FLD_FB_SEL];
    assign out_sel     = cfg_i[TBL_W + FLD_OUT_SEL];
    assign unused_init = cfg_i[TBL_W + FLD_FF_INIT];

    // Feedback replaces input bit 0 with the element's own register
    always_comb begin
        idx = in_i;
        if (fb_sel) idx[0] = ff_q;
    end

    assign lut_out = tbl[idx];
    assign ff_en   = ff_en_sel ? in_i[K-1] : 1'b1;

    // A commit wins over the enable so the FF always starts from ff_init
    always_comb begin
        ff_d = ff_q;
        if (commit_i)   ff_d = init_i;
        else if (ff_en) ff_d = lut_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff_q <= 1'b0;
        else        ff_q <= ff_d;
    end

    assign out_o = out_sel ? ff_q : lut_out;
endmodule

// File: rtl/logic_cluster.sv
// logic_cluster: N configurable K-input logic elements with a daisy-chained
// serial configuration path and atomic, length-checked commit.
//   clk   : fabric clock
//   rst_n : asynchronous active-low reset
//   bus   : logic_cluster_if slave (prog_en/prog_in/prog_out, in/out,
//           cfg_busy/cfg_done/cfg_err)
// Optional feature macro CFG_PARITY_EN: frame carries one extra even-parity
// bit (shifted in last, lands at shadow[0]); commit also requires parity.
module logic_cluster
    import fpga_cfg_pkg::*;
#(
    parameter int K = 4,
    parameter int N = 4
) (
    input logic            clk,
    input logic            rst_n,
    logic_cluster_if.slave bus
);
    localparam int LE_W  = calc_le_w(K);
    localparam int CFG_W = calc_cfg_w(K, N);
`ifdef CFG_PARITY_EN
    localparam int SH_W  = CFG_W + 1;
`else
    localparam int SH_W  = CFG_W;
`endif
    localparam int CNT_MAX = SH_W + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    cfg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SH_W-1:0]  shadow_q, shadow_d;
    logic [CFG_W-1:0] active_q, active_d;
    logic [CFG_W-1:0] cfg_bits;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             frame_ok, commit_ok;
    logic [N-1:0]     out_w;

`ifdef CFG_PARITY_EN
    assign cfg_bits = shadow_q[CFG_W:1];
    assign frame_ok = (cnt_q >= CNT_W'(SH_W)) && !(^shadow_q);
`else
    assign cfg_bits = shadow_q;
    assign frame_ok = (cnt_q >= CNT_W'(SH_W));
`endif
    assign commit_ok = (state_q == ST_COMMIT) && frame_ok;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        done_d   = 1'b0;
        err_d    = err_q;

        // Shadow shifts whenever prog_en is high, in any state
        if (bus.prog_en) shadow_d = {shadow_q[SH_W-2:0], bus.prog_in};

        case (state_q)
            ST_IDLE: begin
                if (bus.prog_en) begin
                    state_d = ST_SHIFT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (bus.prog_en) begin
                    // Saturate just past the frame length; longer frames
                    // belong to downstream clusters
                    if (cnt_q != CNT_W'(CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (frame_ok) begin
                    active_d = cfg_bits;
                    done_d   = 1'b1;
                    err_d    = 1'b0;
                end else begin
                    err_d    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_le
        logic_element_k #(.K(K)) u_le (
            .clk      (clk),
            .rst_n    (rst_n),
            .cfg_i    (active_q[j*LE_W +: LE_W]),
            .commit_i (commit_ok),
            .init_i   (cfg_bits[j*LE_W + (2 ** K) + FLD_FF_INIT]),
            .in_i     (bus.in[j*K +: K]),
            .out_o    (out_w[j])
        );
    end

    assign bus.out      = out_w;
    assign bus.prog_out = shadow_q[SH_W-1];
    assign bus.cfg_busy = (state_q == ST_SHIFT);
    assign bus.cfg_done = done_q;
    assign bus.cfg_err  = err_q;
endmodule

// File: tb/tb_logic_cluster.sv
// Testbench for logic_cluster: two clusters chained on the config path
// (cluster 0 prog_out -> cluster 1 prog_in, shared prog_en).
module tb_logic_cluster;
    import fpga_cfg_pkg::*;

    localparam int K     = 4;
    localparam int N     = 4;
    localparam int CFG_W = calc_cfg_w(K, N);
`ifdef CFG_PARITY_EN
    localparam int SH_W  = CFG_W + 1;
`else
    localparam int SH_W  = CFG_W;
`endif

    localparam int S_OUT0 = 0, S_OUT1 = 1, S_ERR0 = 2, S_ERR1 = 3, S_BUSY0 = 4;
    localparam int S_DONE0 = 5, S_PO0 = 6, S_PO1 = 7, S_BUSY1 = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prog_en, prog_in;
    logic [15:0] in0, in1;

    always #5 clk = ~clk;

    logic_cluster_if #(.K(K), .N(N)) bus0 ();
    logic_cluster_if #(.K(K), .N(N)) bus1 ();

    assign bus0.prog_en = prog_en;
    assign bus0.prog_in = prog_in;
    assign bus0.in      = in0;
    assign bus1.prog_en = prog_en;
    assign bus1.prog_in = bus0.prog_out;
    assign bus1.in      = in1;

    logic_cluster #(.K(K), .N(N)) u_c0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    logic_cluster #(.K(K), .N(N)) u_c1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] mask;
        logic [15:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   done_q0[$];
    int   done_q1[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            S_OUT0:  return {12'b0, bus0.out};
            S_OUT1:  return {12'b0, bus1.out};
            S_ERR0:  return {15'b0, bus0.cfg_err};
            S_ERR1:  return {15'b0, bus1.cfg_err};
            S_BUSY0: return {15'b0, bus0.cfg_busy};
            S_BUSY1: return {15'b0, bus1.cfg_busy};
            S_DONE0: return {15'b0, bus0.cfg_done};
            S_PO0:   return {15'b0, bus0.prog_out};
            S_PO1:   return {15'b0, bus1.prog_out};
            default: return 16'hDEAD;
        endcase
    endfunction

    // Monitor: drain expectations and police cfg_done pulses on each negedge
    initial begin : monitor
        exp_t        e;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = observe(e.sel) & e.mask;
                checks++;
                if (act !== (e.exp & e.mask)) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.tag, act, e.exp & e.mask);
                end
            end
            if (rst_n === 1'b1 && bus0.cfg_done === 1'b1) begin
                checks++;
                if (done_q0.size() == 0) begin
                    errors++;
                    $display("FAIL done0_unexpected: got 1 expected 0");
                end else void'(done_q0.pop_front());
            end
            if (rst_n === 1'b1 && bus1.cfg_done === 1'b1) begin
                checks++;
                if (done_q1.size() == 0) begin
                    errors++;
                    $display("FAIL done1_unexpected: got 1 expected 0");
                end else void'(done_q1.pop_front());
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic expect_sig(input string tag, input int sel,
                              input logic [15:0] mask, input logic [15:0] exp);
        exp_t e;
        e.tag = tag; e.sel = sel; e.mask = mask; e.exp = exp;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    function automatic logic [19:0] mk_le(input logic [15:0] tbl, input logic en_sel,
                                          input logic fb, input logic osel, input logic init);
        return {init, osel, fb, en_sel, tbl};
    endfunction

    function automatic logic [255:0] chain_bits(input logic [CFG_W-1:0] c1,
                                                input logic [CFG_W-1:0] c0);
        logic [255:0] v;
        v = '0;
`ifdef CFG_PARITY_EN
        v[2*SH_W-1:0] = {c1, ^c1, c0, ^c0};
`else
        v[2*SH_W-1:0] = {c1, c0};
`endif
        return v;
    endfunction

    // Sends v[n-1] first, v[0] last
    task automatic shift_bits(input logic [255:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            prog_en = 1'b1;
            prog_in = v[i];
            step();
        end
    endtask

    // Drop prog_en, pass through COMMIT; returns just after the commit edge
    task automatic finish_frame();
        prog_en = 1'b0;
        prog_in = 1'b0;
        step();
        step();
    endtask

    task automatic load_chain(input logic [CFG_W-1:0] c1, input logic [CFG_W-1:0] c0);
        shift_bits(chain_bits(c1, c0), 2 * SH_W);
        done_q0.push_back(1);
        done_q1.push_back(1);
        finish_frame();
    endtask

    logic [19:0]      le_and4, le_or4;
    logic [CFG_W-1:0] c_and, c_or, c_tog;
    logic [255:0]     v;

    initial begin : stim
        le_and4 = mk_le(16'h8000, 1'b0, 1'b0, 1'b0, 1'b0);
        le_or4  = mk_le(16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        c_and   = {le_and4, le_and4, le_and4, le_and4};
        c_or    = {le_or4, le_or4, le_or4, le_or4};
        c_tog   = {20'h0, 20'h0,
                   mk_le(16'hAAAA, 1'b1, 1'b0, 1'b1, 1'b1),
                   mk_le(16'h5555, 1'b0, 1'b1, 1'b1, 1'b0)};

        rst_n = 1'b0; prog_en = 1'b0; prog_in = 1'b0;
        in0 = 16'hFFFF; in1 = 16'hFFFF;
        step();
        expect_sig("rst_out0", S_OUT0, 16'hF, 16'h0);
        expect_sig("rst_out1", S_OUT1, 16'hF, 16'h0);
        expect_sig("rst_busy0", S_BUSY0, 16'h1, 16'h0);
        expect_sig("rst_done0", S_DONE0, 16'h1, 16'h0);
        expect_sig("rst_err0", S_ERR0, 16'h1, 16'h0);
        expect_sig("rst_po0", S_PO0, 16'h1, 16'h0);
        @(negedge clk); #1 rst_n = 1'b1;
        step();

        // AND4 in cluster 0, OR4 in cluster 1 over the chain
        load_chain(c_or, c_and);
        in0 = 16'hFFFF; in1 = 16'h0000;
        expect_sig("and4_all_ones", S_OUT0, 16'hF, 16'hF);
        expect_sig("or4_zero", S_OUT1, 16'hF, 16'h0);
        expect_sig("err0_after_good", S_ERR0, 16'h1, 16'h0);
        step();
        in0 = 16'hFFFE; in1 = 16'h0010;
        expect_sig("and4_in0_E", S_OUT0, 16'hF, 16'hE);
        expect_sig("or4_elem1", S_OUT1, 16'hF, 16'h2);
        step();
        in0 = 16'h7FFF;
        expect_sig("and4_elem3_low", S_OUT0, 16'hF, 16'h7);
        step();

        // Reset in the middle of a shift
        in0 = 16'hFFFF; in1 = 16'hFFFF;
        v = '1;
        shift_bits(v, 40);
        @(negedge clk); #1;
        rst_n = 1'b0; prog_en = 1'b0;
        expect_sig("midrst_out0", S_OUT0, 16'hF, 16'h0);
        expect_sig("midrst_out1", S_OUT1, 16'hF, 16'h0);
        expect_sig("midrst_busy0", S_BUSY0, 16'h1, 16'h0);
        expect_sig("midrst_busy1", S_BUSY1, 16'h1, 16'h0);
        expect_sig("midrst_done0", S_DONE0, 16'h1, 16'h0);
        @(negedge clk); #1 rst_n = 1'b1;
        step();
        shift_bits('0, 40);
        expect_sig("shadow_cleared_po0", S_PO0, 16'h1, 16'h0);
        expect_sig("shadow_cleared_po1", S_PO1, 16'h1, 16'h0);
        expect_sig("busy0_shifting", S_BUSY0, 16'h1, 16'h1);
        finish_frame();
        expect_sig("short40_err0", S_ERR0, 16'h1, 16'h1);
        expect_sig("short40_err1", S_ERR1, 16'h1, 16'h1);
        expect_sig("short40_out0", S_OUT0, 16'hF, 16'h0);
        step();

        // Valid frame clears error; then a 79-bit frame is rejected
        load_chain(c_and, c_and);
        expect_sig("reload_err0", S_ERR0, 16'h1, 16'h0);
        expect_sig("reload_err1", S_ERR1, 16'h1, 16'h0);
        expect_sig("reload_out0", S_OUT0, 16'hF, 16'hF);
        expect_sig("reload_out1", S_OUT1, 16'hF, 16'hF);
        step();
        v = {128'h0, 128'h5A3C_9F01_77E2_C4B8_1D6E_2A90_F35C_0B47};
        shift_bits(v >> 39, 40);
        expect_sig("shift_busy0", S_BUSY0, 16'h1, 16'h1);
        expect_sig("shift_old_cfg_out0", S_OUT0, 16'hF, 16'hF);
        shift_bits(v, 39);
        finish_frame();
        expect_sig("short79_err0", S_ERR0, 16'h1, 16'h1);
        expect_sig("short79_err1", S_ERR1, 16'h1, 16'h1);
        expect_sig("short79_out0_kept", S_OUT0, 16'hF, 16'hF);
        expect_sig("short79_out1_kept", S_OUT1, 16'hF, 16'hF);
        step();

        // Toggle element 0, enable-gated element 1 (in cluster 0)
        in0 = 16'h0000;
        load_chain(c_and, c_tog);
        expect_sig("tog_err0_cleared", S_ERR0, 16'h1, 16'h0);
        expect_sig("tog_c0", S_OUT0, 16'hF, 16'h2);
        step();
        expect_sig("tog_c1", S_OUT0, 16'hF, 16'h3);
        step();
        expect_sig("tog_c2", S_OUT0, 16'hF, 16'h2);
        step();
        expect_sig("tog_c3", S_OUT0, 16'hF, 16'h3);
        step();
        in0 = 16'h0080;
        expect_sig("en1_before_edge", S_OUT0, 16'h2, 16'h2);
        step();
        in0 = 16'h0010;
        expect_sig("en1_captured0", S_OUT0, 16'h2, 16'h0);
        step();
        expect_sig("en1_hold0", S_OUT0, 16'h2, 16'h0);
        in0 = 16'h0090;
        step();
        expect_sig("en1_captured1", S_OUT0, 16'h2, 16'h2);
        in1 = 16'hFFF7;
        expect_sig("c1_and4_elem0_low", S_OUT1, 16'hF, 16'hE);
        step();

`ifdef CFG_PARITY_EN
        // One flipped bit in each cluster's field
        in1 = 16'hFFFF;
        v = chain_bits(c_or, c_and);
        v[5]   = ~v[5];
        v[100] = ~v[100];
        shift_bits(v, 2 * SH_W);
        finish_frame();
        expect_sig("parity_err0", S_ERR0, 16'h1, 16'h1);
        expect_sig("parity_err1", S_ERR1, 16'h1, 16'h1);
        expect_sig("parity_out1_kept", S_OUT1, 16'hF, 16'hF);
        step();
`endif

        step();
        @(negedge clk); #1;
        checks++;
        if (done_q0.size() != 0 || done_q1.size() != 0) begin
            errors++;
            $display("FAIL done_missing: got pending %0d/%0d expected 0/0",
                     done_q0.size(), done_q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
